// File: rtl/u_lsu_pkg.sv
// Shared types and byte-enable helpers for the LSU data-memory responder.
package u_lsu_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [3:0]  re;
    } lsu_req_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] rd;
        logic        err;
    } lsu_rsp_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    function automatic logic be_aligned(input logic [3:0] be,
                                        input logic [1:0] a10);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_B0:   ok = (a10 == 2'd0);
            BE_B1:   ok = (a10 == 2'd1);
            BE_B2:   ok = (a10 == 2'd2);
            BE_B3:   ok = (a10 == 2'd3);
            BE_H0:   ok = (a10 == 2'd0);
            BE_H1:   ok = (a10 == 2'd2);
            BE_W:    ok = (a10 == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/u_lsu_ram.sv
// Single-port DEPTH x 32 data RAM with byte write enables and registered read.
module u_lsu_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] a,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[a][i*8 +: 8] <= wd[i*8 +: 8];
        end
        if (en) rd <= mem[a];
    end

endmodule

// File: rtl/u_lsu.sv
// LSU load/store responder: decode, faults, RD_LAT load pipe.
// Optional request/error counters under LSU_STAT_EN.
module u_lsu
    import u_lsu_pkg::*;
#(
    parameter int          DEPTH    = 1024,
    parameter int          RD_LAT   = 2,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] lsu_a,
    input  logic [3:0]  lsu_we,
    input  logic [31:0] lsu_wd,
    input  logic [3:0]  lsu_re,
    output logic        lsu_vld,
    output logic [31:0] lsu_rd,
    output logic        lsu_err
`ifdef LSU_STAT_EN
    ,
    output logic [31:0] stat_ld,
    output logic [31:0] stat_st,
    output logic [31:0] stat_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    lsu_req_t    req;
    lsu_rsp_t    rsp;
    logic [31:0] off;
    logic [31:0] idx;
    logic        in_range;
    logic        st;
    logic        ld;
    logic        st_ok;
    logic        ld_ok;
    logic [31:0] q;
    logic [31:0] d1;
    logic [31:0] dout;
    logic [31:0] rd_q;
    logic [3:0]  m1;
    logic        st_err;
    logic [RD_LAT-1:0] vp;
    logic [RD_LAT-1:0] ep;

    assign req = '{a: lsu_a, we: lsu_we, wd: lsu_wd, re: lsu_re};

    assign off      = req.a - BASE_ADR;
    assign idx      = {2'b00, off[31:2]};
    assign in_range = (req.a >= BASE_ADR) && (idx < 32'(DEPTH));
    assign st       = |req.we;
    assign ld       = |req.re;
    assign st_ok    = st && in_range && be_aligned(req.we, off[1:0]);
    // A load sharing its cycle with a store never touches the RAM
    assign ld_ok    = ld && !st && in_range && be_aligned(req.re, off[1:0]);

    u_lsu_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk (clk),
        .en  (ld_ok),
        .we  (st_ok ? req.we : 4'b0000),
        .a   (idx[AW-1:0]),
        .wd  (req.wd),
        .rd  (q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vp     <= '0;
            ep     <= '0;
            m1     <= '0;
            st_err <= 1'b0;
        end else begin
            vp[0]  <= ld;
            ep[0]  <= ld && !ld_ok;
            m1     <= req.re;
            st_err <= st && !st_ok;
            for (int k = 1; k < RD_LAT; k++) begin
                vp[k] <= vp[k-1];
                ep[k] <= ep[k-1];
            end
        end
    end

    assign d1 = ep[0] ? 32'h0 :
                q & {{8{m1[3]}}, {8{m1[2]}}, {8{m1[1]}}, {8{m1[0]}}};

    if (RD_LAT == 1) begin : g_direct
        assign dout = d1;
    end else begin : g_pipe
        logic [31:0] dp [RD_LAT-1];
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int k = 0; k < RD_LAT-1; k++) dp[k] <= '0;
            end else begin
                dp[0] <= d1;
                for (int k = 1; k < RD_LAT-1; k++) dp[k] <= dp[k-1];
            end
        end
        assign dout = dp[RD_LAT-2];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        rd_q <= '0;
        else if (rsp.vld) rd_q <= dout;
    end

    always_comb begin
        rsp     = '0;
        rsp.vld = vp[RD_LAT-1];
        rsp.err = (vp[RD_LAT-1] && ep[RD_LAT-1]) || st_err;
        rsp.rd  = rsp.vld ? dout : rd_q;
    end

    assign lsu_vld = rsp.vld;
    assign lsu_rd  = rsp.rd;
    assign lsu_err = rsp.err;

`ifdef LSU_STAT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_ld  <= '0;
            stat_st  <= '0;
            stat_err <= '0;
        end else begin
            if (ld_ok)   stat_ld  <= stat_ld + 32'd1;
            if (st_ok)   stat_st  <= stat_st + 32'd1;
            if (rsp.err) stat_err <= stat_err + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_u_lsu.sv
// Directed bench for u_lsu: vector table plus latency, burst and reset sequences.
module tb_u_lsu;

    localparam int DEPTH  = 1024;
    localparam int RD_LAT = 2;

    logic        clk;
    logic        rstn;
    logic [31:0] lsu_a;
    logic [3:0]  lsu_we;
    logic [31:0] lsu_wd;
    logic [3:0]  lsu_re;
    logic        lsu_vld;
    logic [31:0] lsu_rd;
    logic        lsu_err;
`ifdef LSU_STAT_EN
    logic [31:0] stat_ld;
    logic [31:0] stat_st;
    logic [31:0] stat_err;
`endif

    int checks = 0;
    int errors = 0;

    u_lsu #(
        .DEPTH    (DEPTH),
        .RD_LAT   (RD_LAT),
        .BASE_ADR (32'h0)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .lsu_a   (lsu_a),
        .lsu_we  (lsu_we),
        .lsu_wd  (lsu_wd),
        .lsu_re  (lsu_re),
        .lsu_vld (lsu_vld),
        .lsu_rd  (lsu_rd),
        .lsu_err (lsu_err)
`ifdef LSU_STAT_EN
        ,
        .stat_ld  (stat_ld),
        .stat_st  (stat_st),
        .stat_err (stat_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [3:0]  re;
        logic        ev;
        logic [31:0] erd;
        logic        ee;
    } vec_t;

    vec_t tv [18];

    function automatic vec_t mk(logic [31:0] a, logic [3:0] we,
                                logic [31:0] wd, logic [3:0] re,
                                logic ev, logic [31:0] erd, logic ee);
        vec_t v;
        v.a = a; v.we = we; v.wd = wd; v.re = re;
        v.ev = ev; v.erd = erd; v.ee = ee;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [31:0] a, logic [3:0] we,
                         logic [31:0] wd, logic [3:0] re);
        lsu_a  = a;
        lsu_we = we;
        lsu_wd = wd;
        lsu_re = re;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int lat;
    logic [31:0] got_rd;
    logic got_err;
    logic ev;

    initial begin
        tv[0]  = mk(32'h10, 4'hF, 32'hDEADBEEF, 4'h0, 0, 0, 0);
        tv[1]  = mk(32'h10, 4'h0, 32'h0, 4'hF, 1, 32'hDEADBEEF, 0);
        tv[2]  = mk(32'h10, 4'hF, 32'h11223344, 4'h0, 0, 0, 0);
        tv[3]  = mk(32'h11, 4'h2, 32'h0000AA00, 4'h0, 0, 0, 0);
        tv[4]  = mk(32'h10, 4'h0, 32'h0, 4'hF, 1, 32'h1122AA44, 0);
        tv[5]  = mk(32'h11, 4'h0, 32'h0, 4'h2, 1, 32'h0000AA00, 0);
        tv[6]  = mk(32'h12, 4'h0, 32'h0, 4'hF, 1, 32'h0, 1);
        tv[7]  = mk(32'h1000, 4'h0, 32'h0, 4'hF, 1, 32'h0, 1);
        tv[8]  = mk(32'h10, 4'h0, 32'h0, 4'hF, 1, 32'h1122AA44, 0);
        tv[9]  = mk(32'h13, 4'h3, 32'hFFFFFFFF, 4'h0, 0, 0, 1);
        tv[10] = mk(32'h12, 4'hC, 32'h55660000, 4'h0, 0, 0, 0);
        tv[11] = mk(32'h10, 4'h0, 32'h0, 4'hF, 1, 32'h5566AA44, 0);
        tv[12] = mk(32'h12, 4'h0, 32'h0, 4'hC, 1, 32'h55660000, 0);
        tv[13] = mk(32'h20, 4'hF, 32'h5, 4'hF, 1, 32'h0, 1);
        tv[14] = mk(32'h20, 4'h0, 32'h0, 4'hF, 1, 32'h5, 0);
        tv[15] = mk(32'h13, 4'h0, 32'h0, 4'h8, 1, 32'h55000000, 0);
        tv[16] = mk(32'hFFFFFFFC, 4'hF, 32'h1, 4'h0, 0, 0, 1);
        tv[17] = mk(32'h10, 4'h0, 32'h0, 4'h5, 1, 32'h0, 1);

        rstn = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk("rst_vld", 32'(lsu_vld), 0);
        chk("rst_err", 32'(lsu_err), 0);
        chk("rst_rd", lsu_rd, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(tv[i].a, tv[i].we, tv[i].wd, tv[i].re);
            tick();
            drive(0, 0, 0, 0);
            for (int c = 1; c <= RD_LAT + 1; c++) begin
                if (c > 1) tick();
                ev = tv[i].ev && (c == RD_LAT);
                chk($sformatf("v%0d_c%0d_vld", i, c), 32'(lsu_vld), 32'(ev));
                chk($sformatf("v%0d_c%0d_err", i, c), 32'(lsu_err),
                    32'(tv[i].ee && (tv[i].ev ? (c == RD_LAT) : (c == 1))));
                if (ev) chk($sformatf("v%0d_rd", i), lsu_rd, tv[i].erd);
            end
        end

        // store then load next cycle, measure latency
        drive(32'h40, 4'hF, 32'hDEADBEEF, 4'h0);
        tick();
        drive(32'h40, 4'h0, 32'h0, 4'hF);
        tick();
        drive(0, 0, 0, 0);
        lat = 0;
        got_rd = '0;
        got_err = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            if (lsu_vld && lat == 0) begin
                lat = c;
                got_rd = lsu_rd;
                got_err = lsu_err;
            end
        end
        chk("fwd_latency", 32'(lat), 32'(RD_LAT));
        chk("fwd_rd", got_rd, 32'hDEADBEEF);
        chk("fwd_err", 32'(got_err), 0);

        // back-to-back loads
        for (int j = 0; j < 4; j++) begin
            drive(32'(j * 4), 4'hF, 32'(j + 1), 4'h0);
            tick();
        end
        for (int t = 0; t < RD_LAT + 5; t++) begin
            if (t < 4) drive(32'(t * 4), 4'h0, 32'h0, 4'hF);
            else       drive(0, 0, 0, 0);
            tick();
            ev = (t >= RD_LAT - 1) && (t < RD_LAT + 3);
            chk($sformatf("b2b_t%0d_vld", t), 32'(lsu_vld), 32'(ev));
            if (ev) begin
                chk($sformatf("b2b_t%0d_rd", t), lsu_rd, 32'(t - RD_LAT + 2));
                chk($sformatf("b2b_t%0d_err", t), 32'(lsu_err), 0);
            end
        end

        // reset while a load is in flight
        drive(32'h0, 4'h0, 32'h0, 4'hF);
        tick();
        drive(0, 0, 0, 0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(lsu_vld), 0);
        chk("mid_rst_rd", lsu_rd, 0);
`ifdef LSU_STAT_EN
        chk("stat_ld_rst", stat_ld, 0);
        chk("stat_st_rst", stat_st, 0);
        chk("stat_err_rst", stat_err, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("post_rst_c%0d_vld", c), 32'(lsu_vld), 0);
            chk($sformatf("post_rst_c%0d_err", c), 32'(lsu_err), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
